// File: rtl/pvzbackground_fetch_pkg.sv
// Shared constants and types for the background fetch stage and its camera pan controller.
package pvz_bg_pkg;
    localparam int SRC_W       = 400;
    localparam int SRC_H       = 240;
    localparam int SCALE_SHIFT = 1;
    localparam int PAN_MAX     = 80;
    localparam int HOLD_FRAMES = 120;
    localparam int ADDR_W      = 17;
    localparam int LATENCY     = 3;

    typedef enum logic [1:0] {
        PLAY,
        PAN_OUT,
        HOLD,
        PAN_BACK
    } pan_state_t;
endpackage

// File: rtl/pvzbackground_fetch_if.sv
// Pixel-position, ROM and pan-control signals between the VGA side and the background fetch.
interface pvzbackground_fetch_if;
    import pvz_bg_pkg::*;

    logic              frame_start;
    logic              start_pan;
    logic [9:0]        drawX;
    logic [9:0]        drawY;
    logic              blank_n;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data;
    logic [3:0]        index;
    logic              index_valid;
    logic [7:0]        scroll_x;
    logic              pan_busy;

    modport master (
        output frame_start, start_pan, drawX, drawY, blank_n, rom_data,
        input  rom_addr, index, index_valid, scroll_x, pan_busy
    );

    modport slave (
        input  frame_start, start_pan, drawX, drawY, blank_n, rom_data,
        output rom_addr, index, index_valid, scroll_x, pan_busy
    );
endinterface

// File: rtl/pvzbackground_fetch_pan_ctrl.sv
// Level-intro camera pan: slide right to PAN_MAX, hold for HOLD_FRAMES frames, slide back.
module pvzbackground_pan_ctrl
    import pvz_bg_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       start_pan,
    output logic [7:0] scroll_x,
    output logic       pan_busy
);
    localparam logic [7:0] PAN_LIM = 8'(PAN_MAX);
    localparam logic [7:0] HOLD_N  = 8'(HOLD_FRAMES);

    pan_state_t state, state_nxt;
    logic [7:0] scroll_nxt;
    logic [7:0] hold_cnt, hold_nxt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= PLAY;
            scroll_x <= '0;
            hold_cnt <= '0;
            pan_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            scroll_x <= scroll_nxt;
            hold_cnt <= hold_nxt;
            pan_busy <= (state_nxt != PLAY);
        end
    end

    // scroll_x only moves on frame_start so a frame is never drawn with two offsets
    always_comb begin
        state_nxt  = state;
        scroll_nxt = scroll_x;
        hold_nxt   = hold_cnt;
        case (state)
            PLAY: begin
                if (start_pan) state_nxt = PAN_OUT;
            end
            PAN_OUT: begin
                if (frame_start) begin
                    if (scroll_x >= PAN_LIM) begin
                        state_nxt = HOLD;
                        hold_nxt  = '0;
                    end else begin
                        scroll_nxt = scroll_x + 8'd1;
                        if (scroll_x + 8'd1 == PAN_LIM) begin
                            state_nxt = HOLD;
                            hold_nxt  = '0;
                        end
                    end
                end
            end
            HOLD: begin
                if (frame_start) begin
                    hold_nxt = hold_cnt + 8'd1;
                    if (hold_cnt + 8'd1 == HOLD_N) state_nxt = PAN_BACK;
                end
            end
            PAN_BACK: begin
                if (frame_start) begin
                    if (scroll_x == 8'd0) begin
                        state_nxt = PLAY;
                    end else begin
                        scroll_nxt = scroll_x - 8'd1;
                        if (scroll_x == 8'd1) state_nxt = PLAY;
                    end
                end
            end
            default: state_nxt = PLAY;
        endcase
    end
endmodule

// File: rtl/pvzbackground_fetch.sv
// Maps screen (drawX,drawY) to a scaled, scrolled background ROM address and returns
// the palette index three cycles later, alongside a valid flag for active pixels.
module pvzbackground_fetch
    import pvz_bg_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    pvzbackground_fetch_if.slave bus
);
    logic [7:0]        scroll_x;
    logic              pan_busy;
    logic [9:0]        sx_sum;
    logic [8:0]        sy_div;
    logic [8:0]        src_x;
    logic [7:0]        src_y;
    logic [ADDR_W-1:0] addr_p0;
    logic [ADDR_W-1:0] rom_addr_p1;
    logic              vld_p1, vld_p2, vld_p3;
    logic [3:0]        index_p3;

    function automatic logic [8:0] clamp_x(input logic [9:0] v);
        if (v > 10'(SRC_W - 1)) return 9'(SRC_W - 1);
        return v[8:0];
    endfunction

    function automatic logic [7:0] clamp_y(input logic [8:0] v);
        if (v > 9'(SRC_H - 1)) return 8'(SRC_H - 1);
        return v[7:0];
    endfunction

    pvzbackground_pan_ctrl u_pan (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_start(bus.frame_start),
        .start_pan  (bus.start_pan),
        .scroll_x   (scroll_x),
        .pan_busy   (pan_busy)
    );

    // Stage 0: screen to source coordinates, clamped to the image edge
    always_comb begin
        sx_sum  = 10'(bus.drawX >> SCALE_SHIFT) + {2'b00, scroll_x};
        sy_div  = 9'(bus.drawY >> SCALE_SHIFT);
        src_x   = clamp_x(sx_sum);
        src_y   = clamp_y(sy_div);
        addr_p0 = ADDR_W'(src_y) * ADDR_W'(SRC_W) + ADDR_W'(src_x);
    end

    // Stage 1: address to ROM; stage 2: ROM read in flight; stage 3: index out
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr_p1 <= '0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            vld_p3      <= 1'b0;
            index_p3    <= '0;
        end else begin
            rom_addr_p1 <= addr_p0;
            vld_p1      <= bus.blank_n;
            vld_p2      <= vld_p1;
            vld_p3      <= vld_p2;
            index_p3    <= vld_p2 ? bus.rom_data : 4'd0;
        end
    end

    assign bus.rom_addr    = rom_addr_p1;
    assign bus.index       = index_p3;
    assign bus.index_valid = vld_p3;
    assign bus.scroll_x    = scroll_x;
    assign bus.pan_busy    = pan_busy;
endmodule

// File: tb/tb_pvzbackground_fetch.sv
// Scoreboard bench for the background fetch pipeline and intro pan controller.
module tb_pvzbackground_fetch;
    import pvz_bg_pkg::*;

    typedef struct {
        int          due;
        logic [31:0] val;
        string       tag;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t addr_q[$];
    exp_t idx_q[$];

    pvzbackground_fetch_if bus();

    pvzbackground_fetch dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [3:0] rom_fn(input logic [16:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {3'b000, a[16]};
    endfunction

    // synchronous ROM model: data valid the cycle after the address
    always @(posedge Clk) bus.rom_data <= rom_fn(bus.rom_addr);

    function automatic int exp_addr(input int x, input int y, input int s);
        int sx, sy;
        sx = (x / 2) + s;
        if (sx > 399) sx = 399;
        sy = y / 2;
        if (sy > 239) sy = 239;
        return sy * 400 + sx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", tag, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            e = addr_q.pop_front();
            chk(e.tag, 32'(bus.rom_addr), e.val);
        end
        while (idx_q.size() > 0 && idx_q[0].due <= cyc) begin
            e = idx_q.pop_front();
            chk(e.tag, {27'd0, bus.index_valid, bus.index}, e.val);
        end
    end

    task automatic pix(input int x, input int y, input bit b, input int s, input string tag);
        int   a;
        exp_t e;
        bus.drawX   = 10'(x);
        bus.drawY   = 10'(y);
        bus.blank_n = b;
        a = exp_addr(x, y, s);
        if (b) begin
            e.due = cyc + 1; e.val = 32'(a); e.tag = {tag, "_addr"};
            addr_q.push_back(e);
        end
        e.due = cyc + 3;
        e.val = b ? {27'd0, 1'b1, rom_fn(17'(a))} : 32'd0;
        e.tag = {tag, "_idx"};
        idx_q.push_back(e);
        @(posedge Clk); #1;
    endtask

    task automatic frame(input bit sp);
        bus.frame_start = 1'b1;
        bus.start_pan   = sp;
        bus.blank_n     = 1'b0;
        @(posedge Clk); #1;
        bus.frame_start = 1'b0;
        bus.start_pan   = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) frame(1'b0);
    endtask

    task automatic pan_req();
        bus.start_pan = 1'b1;
        @(posedge Clk); #1;
        bus.start_pan = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.blank_n = 1'b0;
        repeat (n) begin
            @(posedge Clk); #1;
        end
    endtask

    task automatic chk_pan(input string tag, input int s, input bit busy);
        chk({tag, "_scroll"}, 32'(bus.scroll_x), 32'(s));
        chk({tag, "_busy"}, 32'(bus.pan_busy), 32'(busy));
    endtask

    task automatic hit_reset(input string tag);
        #2 Reset = 1'b1;
        #1;
        chk({tag, "_index"}, 32'(bus.index), 32'd0);
        chk({tag, "_valid"}, 32'(bus.index_valid), 32'd0);
        chk_pan(tag, 0, 1'b0);
        addr_q.delete();
        idx_q.delete();
        @(posedge Clk); #1;
        Reset = 1'b0;
    endtask

    initial begin
        Reset           = 1'b1;
        bus.frame_start = 1'b0;
        bus.start_pan   = 1'b0;
        bus.drawX       = '0;
        bus.drawY       = '0;
        bus.blank_n     = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_index", 32'(bus.index), 32'd0);
        chk("rst_valid", 32'(bus.index_valid), 32'd0);
        chk_pan("rst", 0, 1'b0);
        Reset = 1'b0;
        idle(2);

        // basic lookup: (10,7) at scroll 0 is source (5,3)
        pix(10, 7, 1'b1, 0, "px_a");
        pix(11, 7, 1'b1, 0, "px_b");
        pix(300, 200, 1'b1, 0, "px_c");
        idle(4);

        // blanked pixel whose ROM word is 9, then a mixed active/blank run
        pix(18, 0, 1'b0, 0, "blank9");
        for (int i = 0; i < 16; i++)
            pix((i * 37) % 640, (i * 29) % 480, ((i % 3) != 1), 0, $sformatf("mix%0d", i));
        pix(1023, 1023, 1'b1, 0, "clamp");
        pix(639, 479, 1'b1, 0, "corner");
        idle(4);

        // asynchronous reset while active pixels are in flight
        for (int i = 0; i < 4; i++) pix(100 + i, 50, 1'b1, 0, $sformatf("pre%0d", i));
        chk("rst_mid_pre_valid", 32'(bus.index_valid), 32'd1);
        hit_reset("rst_mid");
        idle(2);

        // full intro pan
        pan_req();
        chk_pan("pan_start", 0, 1'b1);
        frames(79);
        chk_pan("pan_79", 79, 1'b1);
        frames(1);
        chk_pan("pan_max", 80, 1'b1);
        pix(639, 0, 1'b1, 80, "pan_edge");
        pix(0, 0, 1'b1, 80, "pan_left");
        idle(4);
        frames(119);
        chk_pan("hold_119", 80, 1'b1);
        frames(1);
        chk_pan("hold_120", 80, 1'b1);
        frames(1);
        chk_pan("back_1", 79, 1'b1);
        frames(78);
        chk_pan("back_79", 1, 1'b1);
        frames(1);
        chk_pan("back_done", 0, 1'b0);

        // start_pan coincident with frame_start, then start_pan during HOLD
        frame(1'b1);
        chk_pan("coinc_0", 0, 1'b1);
        frame(1'b0);
        chk_pan("coinc_1", 1, 1'b1);
        frames(79);
        chk_pan("coinc_max", 80, 1'b1);
        frames(60);
        pan_req();
        chk_pan("hold_req", 80, 1'b1);
        frames(59);
        chk_pan("hold_req_119", 80, 1'b1);
        frames(1);
        chk_pan("hold_req_120", 80, 1'b1);
        frames(1);
        chk_pan("hold_req_back", 79, 1'b1);
        frames(79);
        chk_pan("hold_req_done", 0, 1'b0);

        // reset partway through PAN_OUT, then restart
        pan_req();
        frames(40);
        chk_pan("mid_40", 40, 1'b1);
        pix(0, 0, 1'b1, 40, "pan40");
        hit_reset("rst_pan");
        frames(1);
        chk_pan("rst_pan_play", 0, 1'b0);
        pan_req();
        chk_pan("restart", 0, 1'b1);
        frame(1'b0);
        chk_pan("restart_1", 1, 1'b1);
        pix(0, 0, 1'b1, 1, "restart_px");
        idle(5);

        chk("drain", 32'(addr_q.size() + idx_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
